// File: rtl/target_table_loader.sv
// target_table_loader
//   Writer side of the PC branch-target lookup. Holds a 2**IDX_W-entry table
//   of TGT_W-bit branch targets that the fetch unit reads combinationally,
//   and reloads it at run time from a byte stream over valid/ready.
//   Each entry arrives as a low byte followed by a high byte whose upper bits
//   must be zero (otherwise Err is raised, but the entry is still written).
//   The supported range is 9 <= TGT_W <= 15.
//
// Ports:
//   Clk, Reset_n          clock, asynchronous active-low reset
//   Load_start            one-cycle burst request (honoured in IDLE only)
//   Load_base, Load_count first index and entry count (count clamped to depth)
//   In_valid, In_data     host byte stream
//   In_ready              loader accepts a byte this cycle
//   Busy, Done, Err       burst in progress / completion pulse / sticky error
//   Addr, Target          combinational read port for fetch
module target_table_loader #(
    parameter int unsigned IDX_W = 4,
    parameter int unsigned TGT_W = 12
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               Load_start,
    input  logic [IDX_W-1:0]   Load_base,
    input  logic [IDX_W:0]     Load_count,
    input  logic               In_valid,
    input  logic [7:0]         In_data,
    output logic               In_ready,
    output logic               Busy,
    output logic               Done,
    output logic               Err,
    input  logic [IDX_W-1:0]   Addr,
    output logic [TGT_W-1:0]   Target
);

    localparam int unsigned    DEPTH   = 2 ** IDX_W;
    localparam int unsigned    HI_W    = TGT_W - 8;
    localparam logic [IDX_W:0] CNT_MAX = {1'b1, {IDX_W{1'b0}}};
    localparam logic [IDX_W:0] CNT_ONE = {{IDX_W{1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0] PTR_ONE = {{(IDX_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t           state_q;
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W:0]   rem_q;
    logic [7:0]       lo_q;
    logic             in_ready_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic [TGT_W-1:0] tbl_q [DEPTH];
    logic [IDX_W:0]   count_d;

    // Requests larger than the table are clamped to one full pass.
    assign count_d = (Load_count > CNT_MAX) ? CNT_MAX : Load_count;

    // Outputs are registered: each transition also sets the flags that
    // belong to the destination state.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            rem_q      <= '0;
            lo_q       <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                tbl_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (Load_start) begin
                        err_q <= 1'b0;
                        ptr_q <= Load_base;
                        rem_q <= count_d;
                        if (count_d == '0) begin
                            state_q <= FIN;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= LO;
                            in_ready_q <= 1'b1;
                            busy_q     <= 1'b1;
                        end
                    end
                end
                LO: begin
                    if (In_valid) begin
                        lo_q    <= In_data;
                        state_q <= HI;
                    end
                end
                HI: begin
                    if (In_valid) begin
                        tbl_q[ptr_q] <= {In_data[HI_W-1:0], lo_q};
                        if (|In_data[7:HI_W]) begin
                            err_q <= 1'b1;
                        end
                        ptr_q <= ptr_q + PTR_ONE;
                        rem_q <= rem_q - CNT_ONE;
                        if (rem_q == CNT_ONE) begin
                            state_q    <= FIN;
                            done_q     <= 1'b1;
                            busy_q     <= 1'b0;
                            in_ready_q <= 1'b0;
                        end else begin
                            state_q <= LO;
                        end
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign In_ready = in_ready_q;
    assign Busy     = busy_q;
    assign Done     = done_q;
    assign Err      = err_q;
    assign Target   = tbl_q[Addr];

endmodule

// File: tb/tb_target_table_loader.sv
// tb_target_table_loader
//   Directed self-checking bench for target_table_loader. Inputs change 1 ns
//   after the rising edge; outputs are sampled in the same low-activity window.
module tb_target_table_loader;

    logic        Clk;
    logic        Reset_n;
    logic        Load_start;
    logic [3:0]  Load_base;
    logic [4:0]  Load_count;
    logic        In_valid;
    logic [7:0]  In_data;
    logic        In_ready;
    logic        Busy;
    logic        Done;
    logic        Err;
    logic [3:0]  Addr;
    logic [11:0] Target;

    int checks   = 0;
    int failures = 0;

    target_table_loader #(
        .IDX_W (4),
        .TGT_W (12)
    ) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .Load_start (Load_start),
        .Load_base  (Load_base),
        .Load_count (Load_count),
        .In_valid   (In_valid),
        .In_data    (In_data),
        .In_ready   (In_ready),
        .Busy       (Busy),
        .Done       (Done),
        .Err        (Err),
        .Addr       (Addr),
        .Target     (Target)
    );

    initial Clk = 1'b0;
    always #50 Clk = ~Clk;

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_tgt(input string tag, input logic [3:0] a, input logic [11:0] exp);
        Addr = a;
        #1;
        check(tag, 32'(Target), 32'(exp));
    endtask

    task automatic chk_flags(input string tag, input logic rdy, input logic bsy,
                             input logic dn, input logic er);
        check(tag, {28'd0, In_ready, Busy, Done, Err}, {28'd0, rdy, bsy, dn, er});
    endtask

    task automatic start(input logic [3:0] base, input logic [4:0] cnt);
        Load_start = 1'b1;
        Load_base  = base;
        Load_count = cnt;
        step();
        Load_start = 1'b0;
    endtask

    // One byte transfer; the loader is expected to be ready on this cycle.
    task automatic send(input logic [7:0] b);
        In_valid = 1'b1;
        In_data  = b;
        step();
        In_valid = 1'b0;
        In_data  = 8'hxx;
    endtask

    initial begin
        Reset_n    = 1'b0;
        Load_start = 1'b0;
        Load_base  = '0;
        Load_count = '0;
        In_valid   = 1'b0;
        In_data    = '0;
        Addr       = '0;
        step();
        step();
        Reset_n = 1'b1;
        step();

        // Reset state
        chk_flags("reset_flags", 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) chk_tgt("reset_tgt", 4'(i), 12'h000);

        // Single entry, index 0
        start(4'd0, 5'd1);
        chk_flags("b1_lo", 1'b1, 1'b1, 1'b0, 1'b0);
        send(8'h04);
        chk_flags("b1_hi", 1'b1, 1'b1, 1'b0, 1'b0);
        chk_tgt("b1_before_write", 4'd0, 12'h000);
        send(8'h00);
        chk_flags("b1_fin", 1'b0, 1'b0, 1'b1, 1'b0);
        chk_tgt("b1_tgt0", 4'd0, 12'h004);
        step();
        chk_flags("b1_idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // Wrapping burst 14,15,0
        start(4'd14, 5'd3);
        send(8'h96); send(8'h00);
        send(8'hC2); send(8'h01);
        send(8'h7A);
        chk_flags("b3_last_hi", 1'b1, 1'b1, 1'b0, 1'b0);
        send(8'h02);
        chk_flags("b3_fin", 1'b0, 1'b0, 1'b1, 1'b0);
        chk_tgt("b3_tgt14", 4'd14, 12'h096);
        chk_tgt("b3_tgt15", 4'd15, 12'h1C2);
        chk_tgt("b3_tgt0",  4'd0,  12'h27A);
        chk_tgt("b3_tgt1",  4'd1,  12'h000);
        step();
        chk_flags("b3_idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // Same payload at base 6 with stalls between bytes
        start(4'd6, 5'd3);
        send(8'h96);
        In_data = 8'hFF;
        step(); step();
        chk_flags("gap_hi_hold", 1'b1, 1'b1, 1'b0, 1'b0);
        send(8'h00);
        chk_tgt("gap_tgt6_early", 4'd6, 12'h096);
        In_data = 8'h55;
        step(); step();
        chk_flags("gap_lo_hold", 1'b1, 1'b1, 1'b0, 1'b0);
        chk_tgt("gap_tgt7_nowrite", 4'd7, 12'h000);
        send(8'hC2); step(); send(8'h01); step(); step();
        send(8'h7A); send(8'h02);
        chk_flags("gap_fin", 1'b0, 1'b0, 1'b1, 1'b0);
        chk_tgt("gap_tgt6", 4'd6, 12'h096);
        chk_tgt("gap_tgt7", 4'd7, 12'h1C2);
        chk_tgt("gap_tgt8", 4'd8, 12'h27A);
        chk_tgt("gap_tgt9", 4'd9, 12'h000);
        chk_tgt("gap_tgt14_kept", 4'd14, 12'h096);
        step();

        // Format error: high nibble of the second byte nonzero
        start(4'd5, 5'd1);
        send(8'hEE); send(8'hF3);
        chk_flags("err_fin", 1'b0, 1'b0, 1'b1, 1'b1);
        chk_tgt("err_tgt5", 4'd5, 12'h3EE);
        step();
        chk_flags("err_sticky", 1'b0, 1'b0, 1'b0, 1'b1);

        // Zero-length burst clears Err and writes nothing
        start(4'd5, 5'd0);
        chk_flags("zero_fin", 1'b0, 1'b0, 1'b1, 1'b0);
        chk_tgt("zero_tgt5", 4'd5, 12'h3EE);
        step();
        chk_flags("zero_idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // Load_start while busy is ignored
        start(4'd10, 5'd1);
        start(4'd3, 5'd2);
        chk_flags("ign_still_lo", 1'b1, 1'b1, 1'b0, 1'b0);
        send(8'h55); send(8'h00);
        chk_flags("ign_fin", 1'b0, 1'b0, 1'b1, 1'b0);
        chk_tgt("ign_tgt10", 4'd10, 12'h055);
        chk_tgt("ign_tgt3",  4'd3,  12'h000);
        step();
        chk_flags("ign_idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // Oversized count clamps to a full 16-entry pass from index 0
        start(4'd0, 5'd31);
        for (int i = 0; i < 16; i++) begin
            send(8'(i * 17));
            send(8'(i));
        end
        chk_flags("clamp_fin", 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) chk_tgt("clamp_tgt", 4'(i), 12'((i << 8) | (i * 17)));
        step();
        chk_flags("clamp_idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a burst
        start(4'd2, 5'd2);
        send(8'hAB);
        chk_flags("rst_pre", 1'b1, 1'b1, 1'b0, 1'b0);
        Reset_n = 1'b0;
        #1;
        chk_flags("rst_flags", 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) chk_tgt("rst_tgt", 4'(i), 12'h000);
        step();
        Reset_n = 1'b1;
        step();
        chk_flags("rst_idle", 1'b0, 1'b0, 1'b0, 1'b0);
        // Partial low byte discarded: a fresh burst uses only its own bytes
        start(4'd2, 5'd1);
        send(8'h12); send(8'h03);
        chk_tgt("rst_fresh_tgt2", 4'd2, 12'h312);
        chk_flags("rst_fresh_fin", 1'b0, 1'b0, 1'b1, 1'b0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/target_table_loader.md
Name: target_table_loader

Overview:
- Writer side of the PC branch-target lookup.
- Holds a 16-entry x 12-bit branch-target table that the fetch unit reads combinationally by a 4-bit label index.
- Loads the table at run time from a byte stream over a valid/ready handshake, so targets can be changed per program instead of being fixed in hardware.
- Sits between the program loader/testbench host (write side) and the fetch/PC-select logic (read side).

Parameters:
- IDX_W, 4, index width; table depth = 2**IDX_W = 16.
- TGT_W, 12, target width in bits; each entry arrives as two bytes.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Load_start  in  1  one-cycle request to begin a load burst.
- Load_base  in  4  first table index written by the burst.
- Load_count  in  5  number of entries in the burst; 0..16.
- In_valid  in  1  host has a byte on In_data.
- In_data  in  8  stream byte.
- In_ready  out  1  loader can accept a byte this cycle.
- Busy  out  1  burst in progress.
- Done  out  1  one-cycle pulse when a burst completes.
- Err  out  1  sticky format error for the current/last burst.
- Addr  in  4  read index from fetch.
- Target  out  12  table[Addr], combinational read of registered storage.

Behaviour:
- Reset (asserted, async): all 16 entries = 0. State = IDLE. In_ready=0, Busy=0, Done=0, Err=0. Internal pointer and counter = 0. Target therefore reads 0 for every Addr.
- Reset mid-burst: the burst is abandoned, the table is cleared, and the partial low byte is discarded.
- States: IDLE, LO, HI, FIN.
- IDLE:
  - Load_start=1 with Load_count in 1..16: latch ptr=Load_base, rem=Load_count, clear Err, go to LO.
  - Load_start=1 with Load_count=0: go to FIN, with no writes and Err cleared.
  - Load_count 17..31: clamp to 16.
- Load_start outside IDLE is ignored and has no effect.
- LO:
  - In_ready=1, Busy=1.
  - On In_valid&In_ready, capture In_data as target bits [7:0] and go to HI.
- HI:
  - In_ready=1, Busy=1.
  - On a byte transfer:
    - In_data[3:0] = target bits [11:8].
    - If In_data[7:4] != 0, set Err=1. The entry is still written using bits [3:0].
    - Write table[ptr] = {In_data[3:0], lo_byte}.
    - ptr = ptr+1 mod 16 (15 wraps to 0); rem = rem-1.
    - If the new rem = 0, go to FIN; otherwise go to LO.
- FIN: Done=1 and Busy=0 for exactly one cycle, In_ready=0, then return to IDLE.
- Stalls: In_valid=0 in LO or HI holds the state indefinitely and writes nothing. In_data is ignored when In_valid=0.
- Write visibility:
  - The written value appears on Target (for Addr=ptr) in the cycle after the HI transfer edge.
  - Reads of other entries are unaffected during a burst.
  - Same-cycle read and write of one index returns the old value.
- Bursts longer than 16 entries are impossible (clamped). Overlapping indices within one burst cannot occur.
- Err holds until the next accepted Load_start or reset.
- Throughput: one entry per two accepted bytes. Minimum burst latency = 1 (start) + 2*N transfer cycles + 1 (FIN).

Test Plan:
- Reset, then sweep Addr 0..15 -> Target = 0 for all; In_ready=0, Busy=0, Done=0.
- Load_base=0, Load_count=1, bytes 0x04, 0x00 with In_valid held high -> Busy high for 2 cycles; Done pulses the cycle after the 2nd byte; Target at Addr=0 = 4 (0x004) from the next cycle.
- Load_base=14, Load_count=3, bytes {0x96,0x00},{0xC2,0x01},{0x7A,0x02} -> entries 14=0x096, 15=0x1C2, 0=0x27A (wrap); Done pulses once; entry 1 unchanged.
- Same burst with In_valid toggled 1,0,0,1 between bytes -> identical table result; state holds during gaps; no extra writes.
- Byte pair 0xEE, 0xF3 to index 5 -> table[5]=0x3EE, Err=1 stays high after Done; next Load_start clears Err.
- Load_start with Load_count=0 -> Done one cycle later, no writes. Load_start during Busy -> ignored, and the original burst completes unchanged.
- Assert Reset_n=0 after the first byte of a 2-entry burst -> all outputs and entries = 0 immediately; after release, state is IDLE.
